// File: rtl/ryu_motion_ctrl_if.sv
// ryu_motion_ctrl_if
//   Groups the per-frame control inputs and the sprite-select outputs of
//   the Ryu motion controller.
//   master : the motion controller (consumes keys/tick/kill, drives pose)
//   slave  : the environment / sprite renderer side
//   Signals:
//     frame_tick  1   one-cycle pulse per video frame
//     key_left    1   level, left held
//     key_right   1   level, right held
//     key_up      1   level, jump held
//     key_down    1   level, crouch held
//     key_punch   1   level, punch held
//     kill        1   one-cycle strobe, health reached zero
//     RyuX        10  sprite top-left X
//     RyuY        10  sprite top-left Y
//     sprite      3   pose code
//     busy        1   high while punching or jumping
interface ryu_motion_ctrl_if;
  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       key_punch;
  logic       kill;
  logic [9:0] RyuX;
  logic [9:0] RyuY;
  logic [2:0] sprite;
  logic       busy;

  modport master (
    input  frame_tick, key_left, key_right, key_up, key_down, key_punch, kill,
    output RyuX, RyuY, sprite, busy
  );

  modport slave (
    output frame_tick, key_left, key_right, key_up, key_down, key_punch, kill,
    input  RyuX, RyuY, sprite, busy
  );
endinterface

// File: rtl/ryu_motion_ctrl.sv
// ryu_motion_ctrl
//   Per-frame movement/animation controller for Ryu. Converts decoded key
//   levels and a kill strobe into the sprite position and a 3-bit pose code.
//   State only advances on frame_tick, except that kill is latched at once.
//   Sprite codes: 0 stand, 1 punch, 2 jump, 3 crouch, 4 walk L, 5 walk R, 6 death.
//   Ports:
//     vga_clk  in  1  clock, all state on rising edge
//     reset_n  in  1  synchronous active-low reset
//     mc       master modport of ryu_motion_ctrl_if (keys/tick/kill in,
//              RyuX/RyuY/sprite/busy out, all outputs registered)
module ryu_motion_ctrl #(
  parameter logic [9:0] X_START      = 10'd100,
  parameter logic [9:0] X_MIN        = 10'd0,
  parameter logic [9:0] X_MAX        = 10'd576,
  parameter logic [9:0] GROUND_Y     = 10'd320,
  parameter logic [3:0] WALK_STEP    = 4'd2,
  parameter logic [5:0] JUMP_V0      = 6'd14,
  parameter logic [2:0] GRAVITY      = 3'd1,
  parameter logic [4:0] PUNCH_FRAMES = 5'd12
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  ryu_motion_ctrl_if.master mc
);

  typedef enum logic [2:0] {
    ST_STAND, ST_WALK_L, ST_WALK_R, ST_CROUCH, ST_PUNCH, ST_JUMP, ST_DEAD
  } state_t;

  // Vertical speed on jump entry, two's complement in 7 bits.
  localparam logic [6:0] VY_ENTRY = 7'd0 - {1'b0, JUMP_V0};

  function automatic logic [2:0] sprite_of(input state_t s);
    case (s)
      ST_PUNCH:  return 3'd1;
      ST_JUMP:   return 3'd2;
      ST_CROUCH: return 3'd3;
      ST_WALK_L: return 3'd4;
      ST_WALK_R: return 3'd5;
      ST_DEAD:   return 3'd6;
      default:   return 3'd0;
    endcase
  endfunction

  state_t      r_state, w_state_next;
  logic [9:0]  r_x, w_x_next;
  logic [9:0]  r_y, w_y_next;
  logic [6:0]  r_vy, w_vy_next;
  logic [4:0]  r_punch_cnt, w_punch_cnt_next;
  logic        r_dead;
  logic [2:0]  r_sprite;
  logic        r_busy;

  // Horizontal stepping with saturation, computed in 11 bits so it never wraps.
  logic signed [10:0] w_x_left;
  logic        [10:0] w_x_right;
  logic        [9:0]  w_x_left_sat, w_x_right_sat, w_x_drift;

  // One jump step: shared by jump entry (vy = -V0) and airborne ticks.
  logic        [6:0]  w_vy_in;
  logic signed [10:0] w_y_sum;
  logic               w_land;
  logic        [9:0]  w_y_air;
  logic        [6:0]  w_vy_air;

  // Ground priority decode result: punch > up > down > exactly-one-dir > stand.
  state_t      w_dec_state;
  logic [9:0]  w_dec_x, w_dec_y;
  logic [6:0]  w_dec_vy;
  logic [4:0]  w_dec_cnt;

  always_comb begin
    w_x_left      = $signed({1'b0, r_x}) - $signed({7'd0, WALK_STEP});
    w_x_right     = {1'b0, r_x} + {7'd0, WALK_STEP};
    w_x_left_sat  = (w_x_left < $signed({1'b0, X_MIN})) ? X_MIN : w_x_left[9:0];
    w_x_right_sat = (w_x_right > {1'b0, X_MAX}) ? X_MAX : w_x_right[9:0];
    w_x_drift     = r_x;
    if (mc.key_left && !mc.key_right)      w_x_drift = w_x_left_sat;
    else if (mc.key_right && !mc.key_left) w_x_drift = w_x_right_sat;

    w_vy_in  = (r_state == ST_JUMP) ? r_vy : VY_ENTRY;
    w_y_sum  = $signed({1'b0, r_y}) + $signed({{4{w_vy_in[6]}}, w_vy_in});
    w_land   = (w_y_sum >= $signed({1'b0, GROUND_Y}));
    w_y_air  = w_y_sum[10] ? 10'd0 : w_y_sum[9:0];
    w_vy_air = w_vy_in + {4'd0, GRAVITY};
  end

  always_comb begin
    w_dec_state = ST_STAND;
    w_dec_x     = r_x;
    w_dec_y     = GROUND_Y;
    w_dec_vy    = 7'd0;
    w_dec_cnt   = 5'd0;
    if (mc.key_punch) begin
      w_dec_state = ST_PUNCH;
      w_dec_cnt   = PUNCH_FRAMES - 5'd1;
    end else if (mc.key_up) begin
      // The entry tick already performs the first airborne step.
      w_dec_state = ST_JUMP;
      w_dec_x     = w_x_drift;
      w_dec_y     = w_y_air;
      w_dec_vy    = w_vy_air;
    end else if (mc.key_down) begin
      w_dec_state = ST_CROUCH;
    end else if (mc.key_left && !mc.key_right) begin
      w_dec_state = ST_WALK_L;
      w_dec_x     = w_x_left_sat;
    end else if (mc.key_right && !mc.key_left) begin
      w_dec_state = ST_WALK_R;
      w_dec_x     = w_x_right_sat;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_x_next         = r_x;
    w_y_next         = r_y;
    w_vy_next        = r_vy;
    w_punch_cnt_next = r_punch_cnt;
    if (mc.frame_tick && r_state != ST_DEAD) begin
      if (r_dead || mc.kill) begin
        // Death overrides any action in progress, including busy states.
        w_state_next = ST_DEAD;
        w_y_next     = GROUND_Y;
        w_vy_next    = 7'd0;
      end else begin
        case (r_state)
          ST_PUNCH: begin
            if (r_punch_cnt == 5'd0) begin
              w_state_next     = w_dec_state;
              w_x_next         = w_dec_x;
              w_y_next         = w_dec_y;
              w_vy_next        = w_dec_vy;
              w_punch_cnt_next = w_dec_cnt;
            end else begin
              w_punch_cnt_next = r_punch_cnt - 5'd1;
            end
          end
          ST_JUMP: begin
            w_x_next = w_x_drift;
            if (w_land) begin
              w_state_next = ST_STAND;
              w_y_next     = GROUND_Y;
              w_vy_next    = 7'd0;
            end else begin
              w_y_next  = w_y_air;
              w_vy_next = w_vy_air;
            end
          end
          default: begin
            w_state_next     = w_dec_state;
            w_x_next         = w_dec_x;
            w_y_next         = w_dec_y;
            w_vy_next        = w_dec_vy;
            w_punch_cnt_next = w_dec_cnt;
          end
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state     <= ST_STAND;
      r_x         <= X_START;
      r_y         <= GROUND_Y;
      r_vy        <= 7'd0;
      r_punch_cnt <= 5'd0;
      r_dead      <= 1'b0;
      r_sprite    <= 3'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_vy        <= w_vy_next;
      r_punch_cnt <= w_punch_cnt_next;
      r_dead      <= r_dead | mc.kill;
      r_sprite    <= sprite_of(w_state_next);
      r_busy      <= (w_state_next == ST_PUNCH) || (w_state_next == ST_JUMP);
    end
  end

  assign mc.RyuX   = r_x;
  assign mc.RyuY   = r_y;
  assign mc.sprite = r_sprite;
  assign mc.busy   = r_busy;

endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// tb_ryu_motion_ctrl
//   Directed bench for ryu_motion_ctrl. A second instance starts at X=575
//   to exercise right-edge saturation from an odd coordinate.
module tb_ryu_motion_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ryu_motion_ctrl_if m_if ();
  ryu_motion_ctrl_if e_if ();

  ryu_motion_ctrl u_dut (.vga_clk(clk), .reset_n(reset_n), .mc(m_if.master));
  ryu_motion_ctrl #(.X_START(10'd575)) u_edge (.vga_clk(clk), .reset_n(reset_n), .mc(e_if.master));

  task automatic clear_keys();
    m_if.key_left = 0; m_if.key_right = 0; m_if.key_up = 0;
    m_if.key_down = 0; m_if.key_punch = 0; m_if.kill = 0; m_if.frame_tick = 0;
    e_if.key_left = 0; e_if.key_right = 0; e_if.key_up = 0;
    e_if.key_down = 0; e_if.key_punch = 0; e_if.kill = 0; e_if.frame_tick = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_keys();
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  // One frame tick to both instances; outputs are settled on return.
  task automatic tick();
    @(negedge clk);
    m_if.frame_tick = 1; e_if.frame_tick = 1;
    @(negedge clk);
    m_if.frame_tick = 0; e_if.frame_tick = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_if.RyuX !== 10'd100) begin failures++; $display("FAIL reset_x got=%0d exp=100", m_if.RyuX); end
    checks++; if (m_if.RyuY !== 10'd320) begin failures++; $display("FAIL reset_y got=%0d exp=320", m_if.RyuY); end
    checks++; if (m_if.sprite !== 3'd0) begin failures++; $display("FAIL reset_sprite got=%0d exp=0", m_if.sprite); end
    checks++; if (m_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", m_if.busy); end
    repeat (3) tick();
    checks++; if (m_if.RyuX !== 10'd100 || m_if.RyuY !== 10'd320 || m_if.sprite !== 3'd0 || m_if.busy !== 1'b0) begin
      failures++; $display("FAIL idle_3ticks got x=%0d y=%0d s=%0d b=%0d exp x=100 y=320 s=0 b=0",
                           m_if.RyuX, m_if.RyuY, m_if.sprite, m_if.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_walk();
    do_reset();
    m_if.key_right = 1;
    repeat (5) tick();
    checks++; if (m_if.RyuX !== 10'd110) begin failures++; $display("FAIL walk_r5_x got=%0d exp=110", m_if.RyuX); end
    checks++; if (m_if.sprite !== 3'd5) begin failures++; $display("FAIL walk_r5_sprite got=%0d exp=5", m_if.sprite); end
    // Keep walking no stimulus between ticks: X must not move.
    repeat (4) @(negedge clk);
    checks++; if (m_if.RyuX !== 10'd110) begin failures++; $display("FAIL walk_no_tick_x got=%0d exp=110", m_if.RyuX); end
    repeat (233) tick();
    checks++; if (m_if.RyuX !== 10'd576) begin failures++; $display("FAIL walk_r_to_max got=%0d exp=576", m_if.RyuX); end
    tick();
    checks++; if (m_if.RyuX !== 10'd576) begin failures++; $display("FAIL walk_r_sat got=%0d exp=576", m_if.RyuX); end
    m_if.key_right = 0;
    tick();
    checks++; if (m_if.sprite !== 3'd0 || m_if.RyuX !== 10'd576) begin
      failures++; $display("FAIL walk_release got s=%0d x=%0d exp s=0 x=576", m_if.sprite, m_if.RyuX);
    end
    // Odd starting point 575 must clamp to 576 rather than reaching 577.
    do_reset();
    e_if.key_right = 1;
    tick();
    checks++; if (e_if.RyuX !== 10'd576) begin failures++; $display("FAIL edge_575_step got=%0d exp=576", e_if.RyuX); end
    tick();
    checks++; if (e_if.RyuX !== 10'd576) begin failures++; $display("FAIL edge_576_hold got=%0d exp=576", e_if.RyuX); end
    e_if.key_right = 0;
    // Left edge: 100 -> 0 in 50 ticks, then held at 0.
    do_reset();
    m_if.key_left = 1;
    repeat (50) tick();
    checks++; if (m_if.RyuX !== 10'd0 || m_if.sprite !== 3'd4) begin
      failures++; $display("FAIL walk_l_to_min got x=%0d s=%0d exp x=0 s=4", m_if.RyuX, m_if.sprite);
    end
    tick();
    checks++; if (m_if.RyuX !== 10'd0) begin failures++; $display("FAIL walk_l_sat got=%0d exp=0", m_if.RyuX); end
    $display("test_walk done");
  endtask

  task automatic test_punch();
    do_reset();
    m_if.key_punch = 1;
    tick();
    m_if.key_punch = 0;
    m_if.key_right = 1; // must be ignored while busy
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      checks++; if (m_if.sprite !== 3'd1 || m_if.busy !== 1'b1 || m_if.RyuX !== 10'd100) begin
        failures++; $display("FAIL punch_hold tick=%0d got s=%0d b=%0d x=%0d exp s=1 b=1 x=100",
                             k, m_if.sprite, m_if.busy, m_if.RyuX);
      end
    end
    m_if.key_right = 0;
    tick();
    checks++; if (m_if.sprite !== 3'd0 || m_if.busy !== 1'b0 || m_if.RyuX !== 10'd100) begin
      failures++; $display("FAIL punch_exit got s=%0d b=%0d x=%0d exp s=0 b=0 x=100", m_if.sprite, m_if.busy, m_if.RyuX);
    end
    // Holding punch across the exit tick restarts the punch.
    m_if.key_punch = 1;
    repeat (13) tick();
    checks++; if (m_if.sprite !== 3'd1 || m_if.busy !== 1'b1) begin
      failures++; $display("FAIL punch_restart got s=%0d b=%0d exp s=1 b=1", m_if.sprite, m_if.busy);
    end
    m_if.key_punch = 0;
    // Crouch: held pose, X frozen; released returns to stand.
    do_reset();
    m_if.key_down = 1;
    m_if.key_left = 1;
    tick();
    checks++; if (m_if.sprite !== 3'd3 || m_if.RyuX !== 10'd100) begin
      failures++; $display("FAIL crouch got s=%0d x=%0d exp s=3 x=100", m_if.sprite, m_if.RyuX);
    end
    m_if.key_down = 0;
    m_if.key_left = 0;
    tick();
    checks++; if (m_if.sprite !== 3'd0) begin failures++; $display("FAIL crouch_release got=%0d exp=0", m_if.sprite); end
    $display("test_punch done");
  endtask

  task automatic test_jump();
    int exp_y [29] = '{306, 293, 281, 270, 260, 251, 243, 236, 230, 225, 221, 218, 216, 215, 215,
                       216, 218, 221, 225, 230, 236, 243, 251, 260, 270, 281, 293, 306, 320};
    int errs;
    do_reset();
    errs = 0;
    m_if.key_up = 1;
    for (int k = 0; k < 29; k++) begin
      tick();
      m_if.key_up = 0;
      if (m_if.RyuY !== 10'(exp_y[k])) begin
        errs++; $display("FAIL jump_y tick=%0d got=%0d exp=%0d", k + 1, m_if.RyuY, exp_y[k]);
      end
      if (k < 28 && (m_if.sprite !== 3'd2 || m_if.busy !== 1'b1)) begin
        errs++; $display("FAIL jump_air tick=%0d got s=%0d b=%0d exp s=2 b=1", k + 1, m_if.sprite, m_if.busy);
      end
    end
    checks++; if (errs != 0) failures++;
    checks++; if (m_if.sprite !== 3'd0 || m_if.busy !== 1'b0 || m_if.RyuX !== 10'd100) begin
      failures++; $display("FAIL jump_land got s=%0d b=%0d x=%0d exp s=0 b=0 x=100", m_if.sprite, m_if.busy, m_if.RyuX);
    end
    $display("test_jump done");
  endtask

  task automatic test_left_right();
    do_reset();
    m_if.key_left = 1; m_if.key_right = 1;
    tick();
    checks++; if (m_if.sprite !== 3'd0 || m_if.RyuX !== 10'd100) begin
      failures++; $display("FAIL lr_both got s=%0d x=%0d exp s=0 x=100", m_if.sprite, m_if.RyuX);
    end
    m_if.key_right = 0; m_if.key_up = 1;
    tick();
    m_if.key_up = 0;
    checks++; if (m_if.RyuX !== 10'd98 || m_if.RyuY !== 10'd306) begin
      failures++; $display("FAIL drift_entry got x=%0d y=%0d exp x=98 y=306", m_if.RyuX, m_if.RyuY);
    end
    tick();
    checks++; if (m_if.RyuX !== 10'd96) begin failures++; $display("FAIL drift_t2 got=%0d exp=96", m_if.RyuX); end
    tick();
    checks++; if (m_if.RyuX !== 10'd94 || m_if.RyuY !== 10'd281) begin
      failures++; $display("FAIL drift_t3 got x=%0d y=%0d exp x=94 y=281", m_if.RyuX, m_if.RyuY);
    end
    m_if.key_left = 0;
    repeat (26) tick();
    checks++; if (m_if.sprite !== 3'd0 || m_if.RyuY !== 10'd320 || m_if.RyuX !== 10'd94) begin
      failures++; $display("FAIL drift_land got s=%0d y=%0d x=%0d exp s=0 y=320 x=94", m_if.sprite, m_if.RyuY, m_if.RyuX);
    end
    $display("test_left_right done");
  endtask

  task automatic test_kill();
    do_reset();
    m_if.key_up = 1;
    tick();
    m_if.key_up = 0;
    repeat (2) tick();
    @(negedge clk);
    m_if.kill = 1;
    @(negedge clk);
    m_if.kill = 0;
    repeat (3) @(negedge clk);
    checks++; if (m_if.RyuY !== 10'd281 || m_if.sprite !== 3'd2 || m_if.busy !== 1'b1) begin
      failures++; $display("FAIL kill_no_tick got y=%0d s=%0d b=%0d exp y=281 s=2 b=1", m_if.RyuY, m_if.sprite, m_if.busy);
    end
    tick();
    checks++; if (m_if.sprite !== 3'd6 || m_if.RyuY !== 10'd320 || m_if.busy !== 1'b0 || m_if.RyuX !== 10'd100) begin
      failures++; $display("FAIL kill_tick got s=%0d y=%0d b=%0d x=%0d exp s=6 y=320 b=0 x=100",
                           m_if.sprite, m_if.RyuY, m_if.busy, m_if.RyuX);
    end
    m_if.key_right = 1; m_if.key_up = 1;
    repeat (2) tick();
    checks++; if (m_if.sprite !== 3'd6 || m_if.RyuX !== 10'd100 || m_if.RyuY !== 10'd320) begin
      failures++; $display("FAIL dead_absorb got s=%0d x=%0d y=%0d exp s=6 x=100 y=320", m_if.sprite, m_if.RyuX, m_if.RyuY);
    end
    m_if.key_right = 0; m_if.key_up = 0;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    checks++; if (m_if.sprite !== 3'd0 || m_if.RyuX !== 10'd100 || m_if.RyuY !== 10'd320 || m_if.busy !== 1'b0) begin
      failures++; $display("FAIL dead_reset got s=%0d x=%0d y=%0d b=%0d exp s=0 x=100 y=320 b=0",
                           m_if.sprite, m_if.RyuX, m_if.RyuY, m_if.busy);
    end
    tick();
    checks++; if (m_if.sprite !== 3'd0) begin failures++; $display("FAIL dead_cleared got=%0d exp=0", m_if.sprite); end
    // kill and frame_tick in the same cycle: death on that tick.
    @(negedge clk);
    m_if.kill = 1; m_if.frame_tick = 1;
    @(negedge clk);
    m_if.kill = 0; m_if.frame_tick = 0;
    checks++; if (m_if.sprite !== 3'd6) begin failures++; $display("FAIL kill_with_tick got=%0d exp=6", m_if.sprite); end
    $display("test_kill done");
  endtask

  initial begin
    clear_keys();
    test_reset();
    test_walk();
    test_punch();
    test_jump();
    test_left_right();
    test_kill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
